// File: rtl/peripheral_mpi_mc_wb.sv
`default_nettype none
// ============================================================================
//  Module   : peripheral_mpi_mc_wb
//  Purpose  : Multi-channel message-passing endpoint behind one Wishbone
//             slave. Each channel has a TX staging buffer that software fills
//             flit by flit and then commits, and an RX FIFO of {last, flit}
//             that software drains word by word.
//  Ports    : clk, rst (async, active-high)
//             noc_out_* : per-channel TX flit/last/valid, ready in
//             noc_in_*  : per-channel RX flit/last/valid, ready out
//             wb_*      : Wishbone slave (adr/we/cyc/stb/dat in, dat/ack/err out)
//             irq       : per-channel level interrupt (rx packets pending)
//  Register map (per channel, adr[7:4] = channel, adr[3:2] = register):
//             0x0 DATA  0x4 SEND  0x8 STATUS  0xC CTRL
//  Revision : 1.0 - initial release
// ============================================================================
module peripheral_mpi_mc_wb #(
    parameter int NOC_FLIT_WIDTH = 32,
    parameter int CHANNELS       = 2,
    parameter int DEPTH          = 16
) (
    input  logic                               clk,
    input  logic                               rst,
    output logic [CHANNELS*NOC_FLIT_WIDTH-1:0] noc_out_flit,
    output logic [CHANNELS-1:0]                noc_out_last,
    output logic [CHANNELS-1:0]                noc_out_valid,
    input  logic [CHANNELS-1:0]                noc_out_ready,
    input  logic [CHANNELS*NOC_FLIT_WIDTH-1:0] noc_in_flit,
    input  logic [CHANNELS-1:0]                noc_in_last,
    input  logic [CHANNELS-1:0]                noc_in_valid,
    output logic [CHANNELS-1:0]                noc_in_ready,
    input  logic [31:0]                        wb_adr_i,
    input  logic                               wb_we_i,
    input  logic                               wb_cyc_i,
    input  logic                               wb_stb_i,
    input  logic [31:0]                        wb_dat_i,
    output logic [31:0]                        wb_dat_o,
    output logic                               wb_ack_o,
    output logic                               wb_err_o,
    output logic [CHANNELS-1:0]                irq
);

    localparam int c_W     = NOC_FLIT_WIDTH;
    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;

    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);
    localparam logic [c_CNT_W-1:0] c_CNT_FULL = c_CNT_W'(DEPTH);
    localparam logic [c_PTR_W-1:0] c_PTR_ONE  = c_PTR_W'(1);

    localparam logic [1:0] c_REG_DATA   = 2'd0;
    localparam logic [1:0] c_REG_SEND   = 2'd1;
    localparam logic [1:0] c_REG_STATUS = 2'd2;
    localparam logic [1:0] c_REG_CTRL   = 2'd3;

    // ------------------------------------------------------------------
    // Per-channel state exported to the bus decoder
    // ------------------------------------------------------------------
    logic [CHANNELS-1:0]              w_tx_busy;
    logic [CHANNELS-1:0][c_CNT_W-1:0] w_tx_cnt;
    logic [CHANNELS-1:0][c_CNT_W-1:0] w_rx_flits;
    logic [CHANNELS-1:0][c_CNT_W-1:0] w_rx_pkts;
    logic [CHANNELS-1:0][c_W-1:0]     w_rx_head_flit;
    logic [CHANNELS-1:0]              w_rx_head_last;
    logic [CHANNELS-1:0]              w_irq_en;

    // ------------------------------------------------------------------
    // Bus request sampling. The ack/err cycle blocks re-sampling so every
    // access is exactly two cycles. The decoded operation is held in r_op_*
    // and committed to channel state at the end of the ack cycle.
    // ------------------------------------------------------------------
    logic        r_ack;
    logic        r_err;
    logic [31:0] r_dat;
    logic        r_op_we;
    logic [1:0]  r_op_reg;
    logic [3:0]  r_op_ch;
    logic [31:0] r_op_wdat;

    logic        w_req;
    logic [3:0]  w_ch;
    logic [1:0]  w_reg;
    logic        w_ack_n;
    logic        w_err_n;
    logic [31:0] w_dat_n;

    logic               w_ok;
    logic               w_s_busy;
    logic [c_CNT_W-1:0] w_s_cnt;
    logic [c_CNT_W-1:0] w_s_flits;
    logic [c_CNT_W-1:0] w_s_pkts;
    logic [c_W-1:0]     w_s_head;
    logic               w_s_head_last;
    logic               w_s_irq_en;

    logic w_unused;
    assign w_unused = &{1'b0, wb_adr_i[31:8], wb_adr_i[1:0], r_op_wdat};

    assign w_req = wb_cyc_i & wb_stb_i & ~r_ack & ~r_err;
    assign w_ch  = wb_adr_i[7:4];
    assign w_reg = wb_adr_i[3:2];

    // Select the addressed channel's state; out-of-range leaves w_ok low.
    always_comb begin
        w_ok          = 1'b0;
        w_s_busy      = 1'b0;
        w_s_cnt       = '0;
        w_s_flits     = '0;
        w_s_pkts      = '0;
        w_s_head      = '0;
        w_s_head_last = 1'b0;
        w_s_irq_en    = 1'b0;
        for (int c = 0; c < CHANNELS; c++) begin
            if (w_ch == 4'(c)) begin
                w_ok          = 1'b1;
                w_s_busy      = w_tx_busy[c];
                w_s_cnt       = w_tx_cnt[c];
                w_s_flits     = w_rx_flits[c];
                w_s_pkts      = w_rx_pkts[c];
                w_s_head      = w_rx_head_flit[c];
                w_s_head_last = w_rx_head_last[c];
                w_s_irq_en    = w_irq_en[c];
            end
        end
    end

    always_comb begin
        w_ack_n = 1'b0;
        w_err_n = 1'b0;
        w_dat_n = '0;
        if (w_req) begin
            if (!w_ok) begin
                w_err_n = 1'b1;
            end else begin
                case (w_reg)
                    c_REG_DATA: begin
                        if (wb_we_i) begin
                            if ((w_s_cnt == c_CNT_FULL) || w_s_busy) w_err_n = 1'b1;
                            else                                    w_ack_n = 1'b1;
                        end else begin
                            if (w_s_flits == '0) begin
                                w_err_n = 1'b1;
                            end else begin
                                w_ack_n = 1'b1;
                                w_dat_n = 32'(w_s_head);
                            end
                        end
                    end
                    c_REG_SEND: begin
                        if (wb_we_i) begin
                            if ((w_s_cnt == '0) || w_s_busy) w_err_n = 1'b1;
                            else                            w_ack_n = 1'b1;
                        end else begin
                            w_ack_n = 1'b1;
                            // Head marker is only meaningful with data present
                            w_dat_n = {31'b0, w_s_head_last & (w_s_flits != '0)};
                        end
                    end
                    c_REG_STATUS: begin
                        if (wb_we_i) begin
                            w_err_n = 1'b1;
                        end else begin
                            w_ack_n = 1'b1;
                            w_dat_n = {w_s_busy, 7'b0, 8'(w_s_pkts), 8'(w_s_flits), 8'(w_s_cnt)};
                        end
                    end
                    c_REG_CTRL: begin
                        w_ack_n = 1'b1;
                        w_dat_n = wb_we_i ? 32'b0 : {31'b0, w_s_irq_en};
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ack     <= 1'b0;
            r_err     <= 1'b0;
            r_dat     <= '0;
            r_op_we   <= 1'b0;
            r_op_reg  <= '0;
            r_op_ch   <= '0;
            r_op_wdat <= '0;
        end else begin
            r_ack <= w_ack_n;
            r_err <= w_err_n;
            r_dat <= w_dat_n;
            if (w_ack_n) begin
                r_op_we   <= wb_we_i;
                r_op_reg  <= w_reg;
                r_op_ch   <= w_ch;
                r_op_wdat <= wb_dat_i;
            end
        end
    end

    assign wb_ack_o = r_ack;
    assign wb_err_o = r_err;
    assign wb_dat_o = r_dat;

    // ------------------------------------------------------------------
    // Channels
    // ------------------------------------------------------------------
    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        logic [c_W-1:0]     r_tx_mem [DEPTH];
        logic [c_CNT_W-1:0] r_tx_cnt;
        logic [c_PTR_W-1:0] r_tx_rd;
        logic               r_tx_busy;

        logic [c_W:0]       r_rx_mem [DEPTH];   // {last, flit}
        logic [c_PTR_W-1:0] r_rx_wp;
        logic [c_PTR_W-1:0] r_rx_rp;
        logic [c_CNT_W-1:0] r_rx_flits;
        logic [c_CNT_W-1:0] r_rx_pkts;
        logic               r_rx_rdy;
        logic               r_irq_en;
        logic               r_irq;

        logic               w_cmt;
        logic               w_stage;
        logic               w_send;
        logic               w_pop;
        logic               w_ctrl_wr;
        logic               w_tx_fire;
        logic               w_tx_last;
        logic               w_push;
        logic               w_push_last;
        logic               w_pop_last;
        logic [c_W:0]       w_rx_head;
        logic [c_CNT_W-1:0] w_rx_flits_nxt;

        assign w_cmt     = r_ack && (r_op_ch == 4'(c));
        assign w_stage   = w_cmt &  r_op_we & (r_op_reg == c_REG_DATA);
        assign w_send    = w_cmt &  r_op_we & (r_op_reg == c_REG_SEND);
        assign w_pop     = w_cmt & ~r_op_we & (r_op_reg == c_REG_DATA);
        assign w_ctrl_wr = w_cmt &  r_op_we & (r_op_reg == c_REG_CTRL);

        // ---------------- TX ----------------
        assign w_tx_last = ({1'b0, r_tx_rd} == (r_tx_cnt - c_CNT_ONE));
        assign w_tx_fire = r_tx_busy & noc_out_ready[c];

        always_ff @(posedge clk) begin
            if (w_stage) r_tx_mem[r_tx_cnt[c_PTR_W-1:0]] <= r_op_wdat[c_W-1:0];
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_tx_cnt  <= '0;
                r_tx_rd   <= '0;
                r_tx_busy <= 1'b0;
            end else begin
                if (w_stage) r_tx_cnt <= r_tx_cnt + c_CNT_ONE;
                if (w_send) begin
                    r_tx_busy <= 1'b1;
                    r_tx_rd   <= '0;
                end
                if (w_tx_fire) begin
                    if (w_tx_last) begin
                        r_tx_busy <= 1'b0;
                        r_tx_cnt  <= '0;
                        r_tx_rd   <= '0;
                    end else begin
                        r_tx_rd <= r_tx_rd + c_PTR_ONE;
                    end
                end
            end
        end

        assign noc_out_valid[c]          = r_tx_busy;
        assign noc_out_last[c]           = r_tx_busy & w_tx_last;
        assign noc_out_flit[c*c_W +: c_W] = r_tx_busy ? r_tx_mem[r_tx_rd] : '0;

        // ---------------- RX ----------------
        assign w_push      = noc_in_valid[c] & r_rx_rdy;
        assign w_push_last = w_push & noc_in_last[c];
        assign w_rx_head   = r_rx_mem[r_rx_rp];
        assign w_pop_last  = w_pop & w_rx_head[c_W];

        always_comb begin
            w_rx_flits_nxt = r_rx_flits;
            if (w_push && !w_pop)      w_rx_flits_nxt = r_rx_flits + c_CNT_ONE;
            else if (!w_push && w_pop) w_rx_flits_nxt = r_rx_flits - c_CNT_ONE;
        end

        always_ff @(posedge clk) begin
            if (w_push) r_rx_mem[r_rx_wp] <= {noc_in_last[c], noc_in_flit[c*c_W +: c_W]};
        end

        // Ready is registered from the next fill level so it is 0 in reset
        // and tracks "not full" exactly one edge later.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_rx_wp    <= '0;
                r_rx_rp    <= '0;
                r_rx_flits <= '0;
                r_rx_pkts  <= '0;
                r_rx_rdy   <= 1'b0;
                r_irq_en   <= 1'b0;
                r_irq      <= 1'b0;
            end else begin
                if (w_push) r_rx_wp <= r_rx_wp + c_PTR_ONE;
                if (w_pop)  r_rx_rp <= r_rx_rp + c_PTR_ONE;
                r_rx_flits <= w_rx_flits_nxt;
                r_rx_rdy   <= (w_rx_flits_nxt != c_CNT_FULL);
                if (w_push_last && !w_pop_last)      r_rx_pkts <= r_rx_pkts + c_CNT_ONE;
                else if (!w_push_last && w_pop_last) r_rx_pkts <= r_rx_pkts - c_CNT_ONE;
                if (w_ctrl_wr) r_irq_en <= r_op_wdat[0];
                r_irq <= r_irq_en & (r_rx_pkts != '0);
            end
        end

        assign noc_in_ready[c] = r_rx_rdy;
        assign irq[c]          = r_irq;

        assign w_tx_busy[c]      = r_tx_busy;
        assign w_tx_cnt[c]       = r_tx_cnt;
        assign w_rx_flits[c]     = r_rx_flits;
        assign w_rx_pkts[c]      = r_rx_pkts;
        assign w_rx_head_flit[c] = w_rx_head[c_W-1:0];
        assign w_rx_head_last[c] = w_rx_head[c_W];
        assign w_irq_en[c]       = r_irq_en;
    end

endmodule
`default_nettype wire

// File: tb/tb_peripheral_mpi_mc_wb.sv
`default_nettype none
// ============================================================================
//  Module   : tb_peripheral_mpi_mc_wb
//  Purpose  : Directed self-checking bench for peripheral_mpi_mc_wb
//             (2 channels, 32-bit flits, depth 16).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_peripheral_mpi_mc_wb;

    localparam int W  = 32;
    localparam int CH = 2;
    localparam int D  = 16;

    localparam logic [1:0] R_DATA   = 2'd0;
    localparam logic [1:0] R_SEND   = 2'd1;
    localparam logic [1:0] R_STATUS = 2'd2;
    localparam logic [1:0] R_CTRL   = 2'd3;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [CH*W-1:0] noc_out_flit;
    logic [CH-1:0]   noc_out_last;
    logic [CH-1:0]   noc_out_valid;
    logic [CH-1:0]   noc_out_ready = '0;
    logic [CH*W-1:0] noc_in_flit   = '0;
    logic [CH-1:0]   noc_in_last   = '0;
    logic [CH-1:0]   noc_in_valid  = '0;
    logic [CH-1:0]   noc_in_ready;
    logic [31:0]     wb_adr_i = '0;
    logic            wb_we_i  = 1'b0;
    logic            wb_cyc_i = 1'b0;
    logic            wb_stb_i = 1'b0;
    logic [31:0]     wb_dat_i = '0;
    logic [31:0]     wb_dat_o;
    logic            wb_ack_o;
    logic            wb_err_o;
    logic [CH-1:0]   irq;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    peripheral_mpi_mc_wb #(
        .NOC_FLIT_WIDTH (W),
        .CHANNELS       (CH),
        .DEPTH          (D)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .noc_out_flit  (noc_out_flit),
        .noc_out_last  (noc_out_last),
        .noc_out_valid (noc_out_valid),
        .noc_out_ready (noc_out_ready),
        .noc_in_flit   (noc_in_flit),
        .noc_in_last   (noc_in_last),
        .noc_in_valid  (noc_in_valid),
        .noc_in_ready  (noc_in_ready),
        .wb_adr_i      (wb_adr_i),
        .wb_we_i       (wb_we_i),
        .wb_cyc_i      (wb_cyc_i),
        .wb_stb_i      (wb_stb_i),
        .wb_dat_i      (wb_dat_i),
        .wb_dat_o      (wb_dat_o),
        .wb_ack_o      (wb_ack_o),
        .wb_err_o      (wb_err_o),
        .irq           (irq)
    );

    function automatic logic [31:0] adr(input int ch, input logic [1:0] r);
        return (32'(ch) << 4) | (32'(r) << 2);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One Wishbone access: request sampled at the next edge, response read
    // in the ack cycle, then one idle cycle so side effects are committed.
    task automatic wb_xfer(input logic we, input logic [31:0] a, input logic [31:0] d,
                           output logic ack, output logic err, output logic [31:0] rd);
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = we; wb_adr_i = a; wb_dat_i = d;
        tick();
        ack = wb_ack_o; err = wb_err_o; rd = wb_dat_o;
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
        tick();
    endtask

    task automatic rx_push(input int ch, input logic [W-1:0] f, input logic l);
        logic ok;
        ok = 1'b0;
        noc_in_valid[ch] = 1'b1; noc_in_flit[ch*W +: W] = f; noc_in_last[ch] = l;
        for (int i = 0; i < 20; i++) begin
            if (noc_in_ready[ch]) begin ok = 1'b1; break; end
            tick();
        end
        if (ok) tick();
        noc_in_valid[ch] = 1'b0; noc_in_last[ch] = 1'b0;
        n_total++;
        if (ok !== 1'b1) $display("FAIL rx_push_timeout ch%0d: ready=%b required 1", ch, ok);
        else n_pass++;
    endtask

    task automatic test_reset();
        logic ack, err; logic [31:0] d;
        rst = 1'b1;
        tick(); tick();
        n_total++;
        if ({noc_out_flit, noc_out_last, noc_out_valid, noc_in_ready, wb_dat_o, wb_ack_o, wb_err_o, irq} !== '0)
            $display("FAIL reset_outputs: got %h required 0",
                     {noc_out_flit, noc_out_last, noc_out_valid, noc_in_ready, wb_dat_o, wb_ack_o, wb_err_o, irq});
        else n_pass++;
        rst = 1'b0;
        tick();
        wb_xfer(1'b0, adr(0, R_STATUS), 32'h0, ack, err, d);
        n_total++;
        if ({ack, err} !== 2'b10) $display("FAIL reset_status_ack: ack/err=%b required 10", {ack, err});
        else n_pass++;
        n_total++;
        if (d !== 32'h0) $display("FAIL reset_status_data: got %h required 00000000", d);
        else n_pass++;
    endtask

    task automatic test_tx_ch1();
        logic ack, err; logic [31:0] d; int acks;
        noc_out_ready = '0;
        acks = 0;
        for (int i = 0; i < 3; i++) begin
            wb_xfer(1'b1, adr(1, R_DATA), 32'hA1 + 32'(i), ack, err, d);
            if (ack && !err) acks++;
        end
        n_total++;
        if (acks !== 3) $display("FAIL tx1_stage_acks: got %0d required 3", acks);
        else n_pass++;
        wb_xfer(1'b1, adr(1, R_SEND), 32'h0, ack, err, d);
        n_total++;
        if ({ack, err} !== 2'b10) $display("FAIL tx1_send: ack/err=%b required 10", {ack, err});
        else n_pass++;
        wb_xfer(1'b0, adr(1, R_STATUS), 32'h0, ack, err, d);
        n_total++;
        if (d !== 32'h80000003) $display("FAIL tx1_status_busy: got %h required 80000003", d);
        else n_pass++;
        noc_out_ready[1] = 1'b1;
        for (int i = 0; i < 3; i++) begin
            n_total++;
            if ({noc_out_valid[1], noc_out_last[1], noc_out_flit[63:32]} !== {1'b1, (i == 2), 32'hA1 + 32'(i)})
                $display("FAIL tx1_flit%0d: v/l/flit=%b/%b/%h required 1/%0d/%h",
                         i, noc_out_valid[1], noc_out_last[1], noc_out_flit[63:32], (i == 2), 32'hA1 + 32'(i));
            else n_pass++;
            n_total++;
            if ({noc_out_valid[0], noc_out_last[0], noc_out_flit[31:0]} !== 34'h0)
                $display("FAIL tx1_ch0_quiet%0d: got %h required 0", i,
                         {noc_out_valid[0], noc_out_last[0], noc_out_flit[31:0]});
            else n_pass++;
            tick();
        end
        n_total++;
        if (noc_out_valid[1] !== 1'b0) $display("FAIL tx1_idle: valid=%b required 0", noc_out_valid[1]);
        else n_pass++;
        wb_xfer(1'b0, adr(1, R_STATUS), 32'h0, ack, err, d);
        n_total++;
        if (d !== 32'h0) $display("FAIL tx1_status_done: got %h required 00000000", d);
        else n_pass++;
        noc_out_ready = '0;
    endtask

    task automatic test_tx_backpressure();
        logic ack, err; logic [31:0] d; int acks; int bad;
        wb_xfer(1'b1, adr(0, R_SEND), 32'h0, ack, err, d);
        n_total++;
        if ({ack, err} !== 2'b01) $display("FAIL send_empty: ack/err=%b required 01", {ack, err});
        else n_pass++;
        acks = 0;
        for (int i = 0; i < 4; i++) begin
            wb_xfer(1'b1, adr(0, R_DATA), 32'hB0 + 32'(i), ack, err, d);
            if (ack && !err) acks++;
        end
        wb_xfer(1'b1, adr(0, R_SEND), 32'h0, ack, err, d);
        if (ack && !err) acks++;
        n_total++;
        if (acks !== 5) $display("FAIL bp_stage_send_acks: got %0d required 5", acks);
        else n_pass++;
        wb_xfer(1'b1, adr(0, R_DATA), 32'hEE, ack, err, d);
        n_total++;
        if ({ack, err} !== 2'b01) $display("FAIL data_while_busy: ack/err=%b required 01", {ack, err});
        else n_pass++;
        wb_xfer(1'b1, adr(0, R_SEND), 32'h0, ack, err, d);
        n_total++;
        if ({ack, err} !== 2'b01) $display("FAIL send_while_busy: ack/err=%b required 01", {ack, err});
        else n_pass++;
        noc_out_ready[0] = 1'b1;
        n_total++;
        if ({noc_out_valid[0], noc_out_last[0], noc_out_flit[31:0]} !== {2'b10, 32'hB0})
            $display("FAIL bp_flit0: flit=%h valid=%b required B0/1", noc_out_flit[31:0], noc_out_valid[0]);
        else n_pass++;
        tick();
        noc_out_ready[0] = 1'b0;
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if ({noc_out_valid[0], noc_out_last[0], noc_out_flit[31:0]} !== {2'b10, 32'hB1}) bad++;
        end
        n_total++;
        if (bad !== 0) $display("FAIL bp_stall_stable: %0d unstable cycles, required 0", bad);
        else n_pass++;
        noc_out_ready[0] = 1'b1;
        for (int i = 1; i < 4; i++) begin
            n_total++;
            if ({noc_out_valid[0], noc_out_last[0], noc_out_flit[31:0]} !== {1'b1, (i == 3), 32'hB0 + 32'(i)})
                $display("FAIL bp_flit%0d: v/l/flit=%b/%b/%h required 1/%0d/%h", i,
                         noc_out_valid[0], noc_out_last[0], noc_out_flit[31:0], (i == 3), 32'hB0 + 32'(i));
            else n_pass++;
            tick();
        end
        n_total++;
        if (noc_out_valid[0] !== 1'b0) $display("FAIL bp_idle: valid=%b required 0", noc_out_valid[0]);
        else n_pass++;
        noc_out_ready = '0;
    endtask

    task automatic test_tx_full();
        logic ack, err; logic [31:0] d; int acks; int seen; int bad;
        acks = 0;
        for (int i = 0; i < D; i++) begin
            wb_xfer(1'b1, adr(0, R_DATA), 32'hC00 + 32'(i), ack, err, d);
            if (ack && !err) acks++;
        end
        n_total++;
        if (acks !== D) $display("FAIL full_stage_acks: got %0d required %0d", acks, D);
        else n_pass++;
        wb_xfer(1'b1, adr(0, R_DATA), 32'hDEAD, ack, err, d);
        n_total++;
        if ({ack, err} !== 2'b01) $display("FAIL full_overflow: ack/err=%b required 01", {ack, err});
        else n_pass++;
        wb_xfer(1'b0, adr(0, R_STATUS), 32'h0, ack, err, d);
        n_total++;
        if (d !== 32'h00000010) $display("FAIL full_status: got %h required 00000010", d);
        else n_pass++;
        wb_xfer(1'b1, adr(0, R_SEND), 32'h0, ack, err, d);
        noc_out_ready[0] = 1'b1;
        seen = 0; bad = 0;
        for (int i = 0; i < 40 && noc_out_valid[0]; i++) begin
            if (noc_out_flit[31:0] !== 32'hC00 + 32'(seen) || noc_out_last[0] !== (seen == D - 1)) bad++;
            seen++;
            tick();
        end
        n_total++;
        if (seen !== D || bad !== 0) $display("FAIL full_drain: flits=%0d bad=%0d required %0d/0", seen, bad, D);
        else n_pass++;
        noc_out_ready = '0;
        wb_xfer(1'b0, adr(0, R_STATUS), 32'h0, ack, err, d);
        n_total++;
        if (d !== 32'h0) $display("FAIL full_status_after: got %h required 00000000", d);
        else n_pass++;
    endtask

    task automatic test_rx_irq();
        logic ack, err; logic [31:0] d;
        wb_xfer(1'b1, adr(0, R_CTRL), 32'h1, ack, err, d);
        wb_xfer(1'b0, adr(0, R_CTRL), 32'h0, ack, err, d);
        n_total++;
        if (d !== 32'h1) $display("FAIL ctrl_readback: got %h required 00000001", d);
        else n_pass++;
        rx_push(0, 32'h11, 1'b0);
        rx_push(0, 32'h12, 1'b1);
        rx_push(0, 32'h21, 1'b1);
        tick();
        wb_xfer(1'b0, adr(0, R_STATUS), 32'h0, ack, err, d);
        n_total++;
        if (d !== 32'h00020300) $display("FAIL rx_status: got %h required 00020300", d);
        else n_pass++;
        n_total++;
        if (irq[0] !== 1'b1) $display("FAIL rx_irq_set: irq0=%b required 1", irq[0]);
        else n_pass++;
        wb_xfer(1'b0, adr(0, R_SEND), 32'h0, ack, err, d);
        n_total++;
        if (d !== 32'h0) $display("FAIL rx_head_last: got %h required 00000000", d);
        else n_pass++;
        wb_xfer(1'b0, adr(0, R_DATA), 32'h0, ack, err, d);
        n_total++;
        if ({ack, err, d} !== {2'b10, 32'h11}) $display("FAIL rx_pop0: ack/err=%b data=%h required 10/11", {ack, err}, d);
        else n_pass++;
        wb_xfer(1'b0, adr(0, R_DATA), 32'h0, ack, err, d);
        n_total++;
        if ({ack, err, d} !== {2'b10, 32'h12}) $display("FAIL rx_pop1: ack/err=%b data=%h required 10/12", {ack, err}, d);
        else n_pass++;
        n_total++;
        if (irq[0] !== 1'b1) $display("FAIL rx_irq_hold: irq0=%b required 1", irq[0]);
        else n_pass++;
        wb_xfer(1'b0, adr(0, R_DATA), 32'h0, ack, err, d);
        n_total++;
        if ({ack, err, d} !== {2'b10, 32'h21}) $display("FAIL rx_pop2: ack/err=%b data=%h required 10/21", {ack, err}, d);
        else n_pass++;
        n_total++;
        if (irq[0] !== 1'b1) $display("FAIL rx_irq_lag: irq0=%b required 1", irq[0]);
        else n_pass++;
        tick();
        n_total++;
        if (irq[0] !== 1'b0) $display("FAIL rx_irq_clear: irq0=%b required 0", irq[0]);
        else n_pass++;
        wb_xfer(1'b0, adr(0, R_DATA), 32'h0, ack, err, d);
        n_total++;
        if ({ack, err, d} !== {2'b01, 32'h0}) $display("FAIL rx_pop_empty: ack/err=%b data=%h required 01/0", {ack, err}, d);
        else n_pass++;
    endtask

    task automatic test_rx_full();
        logic ack, err; logic [31:0] d; int bad;
        for (int i = 0; i < D; i++) rx_push(1, 32'h100 + 32'(i), 1'b0);
        n_total++;
        if (noc_in_ready[1] !== 1'b0) $display("FAIL rxfull_ready_low: ready=%b required 0", noc_in_ready[1]);
        else n_pass++;
        noc_in_valid[1] = 1'b1; noc_in_flit[63:32] = 32'h1FF; noc_in_last[1] = 1'b1;
        bad = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (noc_in_ready[1] !== 1'b0) bad++;
        end
        wb_xfer(1'b0, adr(1, R_STATUS), 32'h0, ack, err, d);
        n_total++;
        if (bad !== 0 || d !== 32'h00001000)
            $display("FAIL rxfull_hold: bad=%0d status=%h required 0/00001000", bad, d);
        else n_pass++;
        wb_xfer(1'b0, adr(1, R_DATA), 32'h0, ack, err, d);
        n_total++;
        if (d !== 32'h100) $display("FAIL rxfull_pop: got %h required 00000100", d);
        else n_pass++;
        n_total++;
        if (noc_in_ready[1] !== 1'b1) $display("FAIL rxfull_ready_rise: ready=%b required 1", noc_in_ready[1]);
        else n_pass++;
        tick();
        noc_in_valid[1] = 1'b0; noc_in_last[1] = 1'b0;
        n_total++;
        if (noc_in_ready[1] !== 1'b0) $display("FAIL rxfull_refill: ready=%b required 0", noc_in_ready[1]);
        else n_pass++;
        wb_xfer(1'b0, adr(1, R_STATUS), 32'h0, ack, err, d);
        n_total++;
        if (d !== 32'h00011000) $display("FAIL rxfull_status: got %h required 00011000", d);
        else n_pass++;
        wb_xfer(1'b0, adr(1, R_DATA), 32'h0, ack, err, d);
        n_total++;
        if (d !== 32'h101) $display("FAIL rxfull_order: got %h required 00000101", d);
        else n_pass++;
    endtask

    task automatic test_bad_addr();
        logic ack, err; logic [31:0] d;
        wb_xfer(1'b1, adr(CH, R_DATA), 32'h55, ack, err, d);
        n_total++;
        if ({ack, err, d} !== {2'b01, 32'h0}) $display("FAIL bad_ch_write: ack/err=%b data=%h required 01/0", {ack, err}, d);
        else n_pass++;
        wb_xfer(1'b0, adr(15, R_STATUS), 32'h0, ack, err, d);
        n_total++;
        if ({ack, err} !== 2'b01) $display("FAIL bad_ch15_read: ack/err=%b required 01", {ack, err});
        else n_pass++;
        wb_xfer(1'b0, adr(0, R_STATUS), 32'h0, ack, err, d);
        n_total++;
        if (d !== 32'h0) $display("FAIL bad_no_side_effect: ch0 status %h required 00000000", d);
        else n_pass++;
        wb_xfer(1'b1, adr(0, R_STATUS), 32'h1, ack, err, d);
        n_total++;
        if ({ack, err} !== 2'b01) $display("FAIL status_write: ack/err=%b required 01", {ack, err});
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        logic ack, err; logic [31:0] d;
        noc_out_ready = '0;
        wb_xfer(1'b1, adr(0, R_DATA), 32'h77, ack, err, d);
        wb_xfer(1'b1, adr(0, R_DATA), 32'h78, ack, err, d);
        wb_xfer(1'b1, adr(0, R_SEND), 32'h0, ack, err, d);
        n_total++;
        if ({noc_out_valid[0], noc_out_flit[31:0]} !== {1'b1, 32'h77})
            $display("FAIL rstmid_busy: valid=%b flit=%h required 1/77", noc_out_valid[0], noc_out_flit[31:0]);
        else n_pass++;
        #2 rst = 1'b1;
        #1;
        n_total++;
        if ({noc_out_valid, noc_in_ready, irq} !== '0)
            $display("FAIL rstmid_async: valid/ready/irq=%b required 0", {noc_out_valid, noc_in_ready, irq});
        else n_pass++;
        tick(); tick();
        rst = 1'b0;
        tick();
        wb_xfer(1'b0, adr(0, R_STATUS), 32'h0, ack, err, d);
        n_total++;
        if (d !== 32'h0) $display("FAIL rstmid_status0: got %h required 00000000", d);
        else n_pass++;
        wb_xfer(1'b0, adr(1, R_STATUS), 32'h0, ack, err, d);
        n_total++;
        if (d !== 32'h0) $display("FAIL rstmid_status1: got %h required 00000000", d);
        else n_pass++;
        wb_xfer(1'b0, adr(0, R_CTRL), 32'h0, ack, err, d);
        n_total++;
        if (d !== 32'h0) $display("FAIL rstmid_ctrl: got %h required 00000000", d);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_tx_ch1();
        test_tx_backpressure();
        test_tx_full();
        test_rx_irq();
        test_rx_full();
        test_bad_addr();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, checks %0d/%0d", n_pass, n_total);
        $fatal(1);
    end

endmodule
`default_nettype wire
